// File: rtl/joltage_collector.sv
// Collects one decimal digit per beat into a per-line joltage and a running total.
// Latency: line results register on the newline beat; line_valid pulses the following cycle.
// Backpressure: ready drops in IDLE, EMIT and DONE; upstream holds its beat until ready returns.
module joltage_collector #(
  parameter int DIGITS      = 12,
  parameter int LINE_WIDTH  = 40,
  parameter int SUM_WIDTH   = 64,
  parameter int COUNT_WIDTH = 16,
  parameter int DATA_WIDTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_in_valid,
  input  logic                   newline,
  input  logic                   last_in,
  output logic                   ready,
  output logic                   line_valid,
  output logic [LINE_WIDTH-1:0]  line_value,
  output logic [SUM_WIDTH-1:0]   total,
  output logic [COUNT_WIDTH-1:0] line_count,
  output logic                   done,
  output logic                   err,
  output logic                   ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} state_e;

  // Digit counter is wide enough that an overlong line cannot wrap back to DIGITS.
  localparam int DCW = 16;
  // Adder width leaves room to observe the carry out of the total.
  localparam int AW  = ((LINE_WIDTH > SUM_WIDTH) ? LINE_WIDTH : SUM_WIDTH) + 1;

  state_e                 state_q, state_d;
  logic [LINE_WIDTH-1:0]  acc_q, acc_d;
  logic [DCW-1:0]         dcount_q, dcount_d;
  logic [LINE_WIDTH-1:0]  line_value_q, line_value_d;
  logic [SUM_WIDTH-1:0]   total_q, total_d;
  logic [COUNT_WIDTH-1:0] line_count_q, line_count_d;
  logic                   err_q, err_d;
  logic                   ovf_q, ovf_d;
  logic                   last_pending_q, last_pending_d;

  logic                   accept;
  logic                   digit_ok;
  logic [LINE_WIDTH-1:0]  acc_new;
  logic [DCW-1:0]         dcnt_new;
  logic [AW-1:0]          sum_full;
  logic                   finalize;

  // Beat datapath: value and digit count as they would stand after this cycle's beat.
  always_comb begin
    accept   = data_in_valid && (state_q == ACCUM);
    digit_ok = (data_in <= DATA_WIDTH'(9));
    acc_new  = acc_q;
    dcnt_new = dcount_q;
    if (accept && digit_ok) begin
      acc_new  = LINE_WIDTH'(acc_q * LINE_WIDTH'(10)) + LINE_WIDTH'(data_in);
      dcnt_new = dcount_q + DCW'(1);
    end
    sum_full = AW'(total_q) + AW'(acc_new);
  end

  // Next-state and result update; a line closes on newline or on last_in with digits pending.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    dcount_d       = dcount_q;
    line_value_d   = line_value_q;
    total_d        = total_q;
    line_count_d   = line_count_q;
    err_d          = err_q;
    ovf_d          = ovf_q;
    last_pending_d = last_pending_q;
    finalize       = 1'b0;
    case (state_q)
      IDLE: state_d = ACCUM;
      ACCUM: begin
        if (accept) begin
          acc_d    = acc_new;
          dcount_d = dcnt_new;
          if (!digit_ok) err_d = 1'b1;
        end
        finalize = (accept && newline) || (last_in && (dcnt_new != '0));
        if (finalize) begin
          line_value_d   = acc_new;
          total_d        = sum_full[SUM_WIDTH-1:0];
          if (sum_full[AW-1:SUM_WIDTH] != '0) ovf_d = 1'b1;
          line_count_d   = line_count_q + COUNT_WIDTH'(1);
          if (dcnt_new != DCW'(DIGITS)) err_d = 1'b1;
          acc_d          = '0;
          dcount_d       = '0;
          last_pending_d = last_in;
          state_d        = EMIT;
        end else if (last_in) begin
          state_d = DONE;
        end
      end
      EMIT:    state_d = last_pending_q ? DONE : ACCUM;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any partial line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      dcount_q       <= '0;
      line_value_q   <= '0;
      total_q        <= '0;
      line_count_q   <= '0;
      err_q          <= 1'b0;
      ovf_q          <= 1'b0;
      last_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      dcount_q       <= dcount_d;
      line_value_q   <= line_value_d;
      total_q        <= total_d;
      line_count_q   <= line_count_d;
      err_q          <= err_d;
      ovf_q          <= ovf_d;
      last_pending_q <= last_pending_d;
    end
  end

  assign ready      = (state_q == ACCUM);
  assign line_valid = (state_q == EMIT);
  assign done       = (state_q == DONE);
  assign line_value = line_value_q;
  assign total      = total_q;
  assign line_count = line_count_q;
  assign err        = err_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_joltage_collector.sv
module tb_joltage_collector;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] data_in = '0;
  logic       data_in_valid = 1'b0;
  logic       newline = 1'b0;
  logic       last_in = 1'b0;

  // DIGITS=2 instance with a narrow total, DIGITS=12 instance with defaults; inputs shared.
  logic        rdy2, lvld2, done2, err2, ovf2;
  logic [39:0] lv2;
  logic [7:0]  tot2;
  logic [15:0] cnt2;
  logic        rdy12, lvld12, done12, err12, ovf12;
  logic [39:0] lv12;
  logic [63:0] tot12;
  logic [15:0] cnt12;

  int n_pass = 0;
  int n_chk  = 0;

  joltage_collector #(.DIGITS(2), .LINE_WIDTH(40), .SUM_WIDTH(8), .COUNT_WIDTH(16)) u_d2 (
    .clock(clock), .reset(reset), .data_in(data_in), .data_in_valid(data_in_valid),
    .newline(newline), .last_in(last_in), .ready(rdy2), .line_valid(lvld2),
    .line_value(lv2), .total(tot2), .line_count(cnt2), .done(done2), .err(err2), .ovf(ovf2)
  );

  joltage_collector #(.DIGITS(12)) u_d12 (
    .clock(clock), .reset(reset), .data_in(data_in), .data_in_valid(data_in_valid),
    .newline(newline), .last_in(last_in), .ready(rdy12), .line_valid(lvld12),
    .line_value(lv12), .total(tot12), .line_count(cnt12), .done(done12), .err(err12), .ovf(ovf12)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reset is pulsed across one negedge; returns at the negedge where the DUT sits in IDLE.
  task automatic do_reset();
    data_in_valid = 1'b0; newline = 1'b0; last_in = 1'b0; data_in = '0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Present a beat and hold it until ready; returns at the negedge after acceptance.
  task automatic send(input logic [3:0] d, input bit nl, input bit lst);
    int n;
    n = 0;
    data_in = d; data_in_valid = 1'b1; newline = nl; last_in = lst;
    while (!rdy2 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) chk("send_timeout", 1, 0);
    @(negedge clock);
    data_in_valid = 1'b0; newline = 1'b0; last_in = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] d;
    bit         nl;
    bit         chk;
    longint     lv;
    longint     tot;
    int         cnt;
    bit         err;
    bit         ovf;
  } vec_t;

  vec_t tbl[14];

  // Random lines checked against a transaction-level model: value is the positional
  // sum of the valid digits, totals are the exact sum reduced mod 2^SUM_WIDTH.
  task automatic run_random();
    logic [127:0] sum2, sum12, v, p;
    logic [3:0]   digs[$];
    logic [3:0]   good[$];
    bit           bad, e2, e12;
    int           len;
    logic [3:0]   d;
    sum2 = 0; sum12 = 0; e2 = 0; e12 = 0;
    do_reset();
    for (int ln = 0; ln < 25; ln++) begin
      digs.delete(); good.delete(); bad = 0;
      len = $urandom_range(1, 13);
      if (ln % 3 == 0) len = 2;
      if (ln % 5 == 1) len = 12;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) d = 4'($urandom_range(10, 15));
        else d = 4'($urandom_range(0, 9));
        digs.push_back(d);
        if (d <= 9) good.push_back(d); else bad = 1;
      end
      v = 0; p = 1;
      for (int i = good.size() - 1; i >= 0; i--) begin
        v = v + 128'(good[i]) * p;
        p = p * 10;
      end
      v = v % (128'(1) << 40);
      sum2  = sum2 + v;
      sum12 = sum12 + v;
      if (bad || good.size() != 2)  e2 = 1;
      if (bad || good.size() != 12) e12 = 1;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clock);
        send(digs[i], (i == len - 1), 1'b0);
      end
      chk("rnd_lvld2", lvld2, 1);
      chk("rnd_lv2", lv2, v);
      chk("rnd_tot2", tot2, sum2 % 256);
      chk("rnd_cnt2", cnt2, ln + 1);
      chk("rnd_err2", err2, e2);
      chk("rnd_ovf2", ovf2, sum2 >= 256);
      chk("rnd_lv12", lv12, v);
      chk("rnd_tot12", tot12, sum12 % (128'(1) << 64));
      chk("rnd_err12", err12, e12);
    end
  endtask

  initial begin
    tbl[0]  = '{1, 9,  0, 0, 0,  0,   0, 0, 0};
    tbl[1]  = '{0, 8,  1, 1, 98, 98,  1, 0, 0};
    tbl[2]  = '{0, 8,  0, 0, 0,  0,   0, 0, 0};
    tbl[3]  = '{0, 9,  1, 1, 89, 187, 2, 0, 0};
    tbl[4]  = '{1, 9,  0, 0, 0,  0,   0, 0, 0};
    tbl[5]  = '{0, 9,  1, 1, 99, 99,  1, 0, 0};
    tbl[6]  = '{0, 9,  0, 0, 0,  0,   0, 0, 0};
    tbl[7]  = '{0, 9,  1, 1, 99, 198, 2, 0, 0};
    tbl[8]  = '{0, 9,  0, 0, 0,  0,   0, 0, 0};
    tbl[9]  = '{0, 9,  1, 1, 99, 41,  3, 0, 1};
    tbl[10] = '{1, 7,  0, 0, 0,  0,   0, 0, 0};
    tbl[11] = '{0, 11, 0, 0, 0,  0,   0, 0, 0};
    tbl[12] = '{0, 3,  1, 1, 73, 73,  1, 1, 0};
    tbl[13] = '{0, 4,  1, 1, 4,  77,  2, 1, 0};

    // Reset values while held in reset, then IDLE occupies the first cycle after release.
    repeat (2) @(negedge clock);
    chk("rst_ready", rdy2, 0);
    chk("rst_lvld", lvld2, 0);
    chk("rst_lv", lv2, 0);
    chk("rst_tot", tot2, 0);
    chk("rst_cnt", cnt2, 0);
    chk("rst_done", done2, 0);
    chk("rst_err", err2, 0);
    chk("rst_ovf", ovf2, 0);
    reset = 1'b1;
    chk("idle_ready", rdy2, 0);
    @(negedge clock);
    chk("accum_ready", rdy2, 1);

    // Table-driven DIGITS=2 sequences: basic lines, overflow, bad digit and short line.
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) do_reset();
      send(tbl[i].d, tbl[i].nl, 1'b0);
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_lvld", i), lvld2, 1);
        chk($sformatf("tbl%0d_lv", i), lv2, tbl[i].lv);
        chk($sformatf("tbl%0d_tot", i), tot2, tbl[i].tot);
        chk($sformatf("tbl%0d_cnt", i), cnt2, tbl[i].cnt);
        chk($sformatf("tbl%0d_err", i), err2, tbl[i].err);
        chk($sformatf("tbl%0d_ovf", i), ovf2, tbl[i].ovf);
      end
    end
    @(negedge clock);
    chk("pulse_one_cycle", lvld2, 0);

    // Twelve-digit lines on the default instance.
    do_reset();
    begin
      logic [3:0] a[12];
      logic [3:0] b[12];
      a = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 1, 1, 1};
      b = '{8, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 9};
      for (int i = 0; i < 12; i++) send(a[i], i == 11, 1'b0);
      chk("d12_lv1", lv12, 40'd987654321111);
      chk("d12_cnt1", cnt12, 1);
      for (int i = 0; i < 12; i++) send(b[i], i == 11, 1'b0);
      chk("d12_lv2", lv12, 40'd811111111119);
      chk("d12_tot", tot12, 64'd1798765432230);
      chk("d12_err", err12, 0);
      chk("d12_ovf", ovf12, 0);
    end

    // A beat presented during EMIT waits one cycle and is taken exactly once.
    do_reset();
    send(1, 0, 0);
    send(2, 1, 0);
    chk("bp_emit_ready", rdy2, 0);
    chk("bp_emit_lvld", lvld2, 1);
    send(5, 0, 0);
    send(6, 1, 0);
    chk("bp_lv", lv2, 56);
    chk("bp_tot", tot2, 68);
    chk("bp_err", err2, 0);

    // last_in together with the newline beat: EMIT then DONE, later beats ignored.
    do_reset();
    send(1, 0, 0);
    send(2, 1, 1);
    chk("eoi_lvld", lvld2, 1);
    chk("eoi_lv", lv2, 12);
    @(negedge clock);
    chk("eoi_done", done2, 1);
    chk("eoi_ready", rdy2, 0);
    data_in = 3; data_in_valid = 1'b1; newline = 1'b1;
    repeat (5) @(negedge clock);
    data_in_valid = 1'b0; newline = 1'b0;
    chk("eoi_tot_held", tot2, 12);
    chk("eoi_cnt_held", cnt2, 1);
    chk("eoi_still_done", done2, 1);

    // last_in on a partial line closes it with a count error.
    do_reset();
    send(5, 0, 0);
    last_in = 1'b1;
    @(negedge clock);
    last_in = 1'b0;
    chk("part_lvld", lvld2, 1);
    chk("part_lv", lv2, 5);
    chk("part_err", err2, 1);
    @(negedge clock);
    chk("part_done", done2, 1);

    // last_in on an empty line goes straight to DONE.
    do_reset();
    @(negedge clock);
    last_in = 1'b1;
    @(negedge clock);
    last_in = 1'b0;
    chk("empty_done", done2, 1);
    chk("empty_lvld", lvld2, 0);
    chk("empty_cnt", cnt2, 0);
    chk("empty_err", err2, 0);

    // Asynchronous reset in EMIT clears everything without a clock edge.
    do_reset();
    send(9, 0, 0);
    send(9, 1, 0);
    chk("mid_pre_tot", tot2, 99);
    #2 reset = 1'b0;
    #1;
    chk("mid_lvld", lvld2, 0);
    chk("mid_lv", lv2, 0);
    chk("mid_tot", tot2, 0);
    chk("mid_cnt", cnt2, 0);
    chk("mid_ready", rdy2, 0);
    @(negedge clock);
    reset = 1'b1;

    run_random();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/joltage_collector.md
# joltage_collector

Back-end collector for the day-3 battery-bank datapath. Consumes the selected-digit stream produced by `top` (one decimal digit per beat, `newline` marking each bank's last digit) and assembles each bank's digits into a decimal joltage. Reports every per-line value and keeps a running puzzle total. Sits directly downstream of `top`, replacing bench-side result checking with an in-fabric answer.

## Interface
Parameters:
- DIGITS, 12, digits expected per line (2 for part 1, 12 for part 2)
- LINE_WIDTH, 40, width of the per-line value; must hold 10^DIGITS − 1
- SUM_WIDTH, 64, width of the running total
- COUNT_WIDTH, 16, width of the line counter

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low (0 = in reset)
- data_in  input  `DATA_WIDTH  digit value 0–9, from `top.data_out`
- data_in_valid  input  1  beat valid, from `top.data_out_valid`
- newline  input  1  qualifies the current beat as the last digit of a line
- last_in  input  1  end of input; sampled only when ready=1
- ready  output  1  collector accepts a beat this cycle
- line_valid  output  1  one-cycle pulse; line_value and total are updated
- line_value  output  LINE_WIDTH  most recent completed line value
- total  output  SUM_WIDTH  running sum of all line values
- line_count  output  COUNT_WIDTH  number of lines completed
- done  output  1  input finished; outputs frozen
- err  output  1  sticky: bad digit or wrong digit count on a line
- ovf  output  1  sticky: total wrapped

## Operation
- States: IDLE, ACCUM, EMIT, DONE. Reset enters IDLE. IDLE → ACCUM unconditionally on the next clock.
- ready = 1 only in ACCUM.
- Beat accepted when data_in_valid && ready.
- Accepted beat with data_in ≤ 9: acc ← acc*10 + data_in; dcount++.
- Accepted beat with data_in > 9: err ← 1; acc and dcount unchanged. newline on the same beat is still honoured.
- Accepted beat with newline=1:
  - line_value ← final acc, including this beat's digit.
  - total ← total + final acc.
  - line_count++.
  - If final dcount ≠ DIGITS, err ← 1.
  - Clear acc and dcount; go to EMIT.
- EMIT lasts exactly one cycle with line_valid=1 and ready=0, then returns to ACCUM. If last_pending is set, it goes to DONE instead.
- last_in:
  - Sampled in ACCUM.
  - With no accepted beat that cycle and dcount = 0: go to DONE.
  - With dcount ≠ 0 and no newline: finalize the partial line exactly as a newline would (err set for the short count), then EMIT → DONE.
  - Together with an accepted newline beat: set last_pending; EMIT → DONE.
- DONE: done=1, ready=0. All outputs hold until reset. Further inputs are ignored.
- Arithmetic:
  - acc*10 is truncated to LINE_WIDTH.
  - total addition is modulo 2^SUM_WIDTH. On a carry-out, ovf ← 1.
  - line_count wraps silently.

## Timing
- Reset values: ready=0, line_valid=0, line_value=0, total=0, line_count=0, done=0, err=0, ovf=0. Internal acc=0, dcount=0, last_pending=0.
- First possible acceptance: second rising edge after reset deasserts (IDLE takes one cycle).
- Throughput: one digit per cycle in ACCUM. Each line costs one extra bubble cycle (EMIT).
- Latency: line_value, total and line_count change at the edge that accepts the newline beat. line_valid is high for the following cycle only.
- Backpressure: upstream must hold data_in, data_in_valid and newline stable while ready=0. The held beat is accepted on the first ACCUM cycle and is never dropped or duplicated.
- Reset asserted mid-line or in EMIT: all state and outputs return to reset values immediately (asynchronous); the partial line is discarded.

## Test plan
- DIGITS=2: beats 9, 8(newline) → line_valid pulse one cycle after the 8; line_value=98, total=98, line_count=1. Then 8, 9(newline) → line_value=89, total=187, line_count=2.
- DIGITS=12: the 12 digits 9,8,7,6,5,4,3,2,1,1,1,1 with newline on the last → line_value=987654321111. Feed a second line 811111111119 → total=1798765432230, err=0.
- Backpressure: present a valid digit 5 on the cycle EMIT is active → not accepted; it is accepted the next cycle, and the next line value includes exactly one 5.
- Errors: DIGITS=2, beats 7, 11, 3(newline) → err=1, line_value=73. A separate line with a single digit 4(newline) → err=1, line_value=4.
- End of input: last_in with newline on the final beat → EMIT then done=1 and ready=0, with total held. Later valid beats leave total unchanged.
- Overflow and reset: SUM_WIDTH=8 with lines 99 and 99 (DIGITS=2) → total=198 with ovf=0; adding 99 again → total=41 with ovf=1. Asserting reset mid-line clears all outputs to 0 within the same cycle.
